// File: rtl/fu_issue_queue_pkg.sv
// Shared types for the FU issue queue: FU class indices, RS issue packet, stall packet.
// fu_class() maps an FU_SELECT code onto its issue-queue class index.
package fu_issue_queue_pkg;

  localparam int FUQ_ALU    = 0;
  localparam int FUQ_LS     = 1;
  localparam int FUQ_MULT   = 2;
  localparam int FUQ_BR     = 3;
  localparam int FUQ_NCLASS = 4;
  localparam int FUQ_DEPTH  = 8;

  typedef enum logic [1:0] {
    ALU_1  = 2'd0,
    LS_1   = 2'd1,
    MULT_1 = 2'd2,
    BRANCH = 2'd3
  } FU_SELECT;

  typedef struct packed {
    logic        valid;
    FU_SELECT    fu_sel;
    logic [31:0] PC;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
  } RS_S_PACKET;

  typedef struct packed {
    logic alu;
    logic ls;
    logic mult;
    logic branch;
  } FU_FIFO_PACKET;

  function automatic logic [1:0] fu_class(input FU_SELECT sel);
    logic [1:0] cls;
    unique case (sel)
      ALU_1:   cls = 2'(FUQ_ALU);
      LS_1:    cls = 2'(FUQ_LS);
      MULT_1:  cls = 2'(FUQ_MULT);
      default: cls = 2'(FUQ_BR);
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/fu_class_fifo.sv
// One FU-class FIFO: 3-wide ordered write (slot 2 first), 1-wide read, squash flush.
// Head visible 1 cycle after write; stall when fewer than 3 entries free (registered count only).
module fu_class_fifo
  import fu_issue_queue_pkg::*;
#(
  parameter int DEPTH = FUQ_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [2:0]               wr_en,
  input  RS_S_PACKET [2:0]         wr_data,
  input  logic                     pop,
  output RS_S_PACKET               head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  RS_S_PACKET      mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   space;
  logic [CW-1:0]   n_enq;
  logic [2:0]      wr_ok;
  logic [PW-1:0]   wr_ptr [3];
  logic            do_pop;

  assign do_pop = pop && (count != '0);

  // A same-cycle pop frees its slot, so it counts toward the room available;
  // lower-priority slots take higher offsets and are the ones dropped when full.
  always_comb begin
    space = CW'(DEPTH) - count + CW'(do_pop);
    n_enq = '0;
    wr_ok = '0;
    for (int k = 0; k < 3; k++) wr_ptr[k] = '0;
    for (int k = 2; k >= 0; k--) begin
      if (wr_en[k] && (n_enq < space)) begin
        wr_ok[k]  = 1'b1;
        wr_ptr[k] = tail + n_enq[PW-1:0];
        n_enq     = n_enq + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(do_pop);
      tail  <= tail + n_enq[PW-1:0];
      count <= count + n_enq - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !squash) begin
      for (int k = 0; k < 3; k++) begin
        if (wr_ok[k]) mem[wr_ptr[k]] <= wr_data[k];
      end
    end
  end

  assign head_data = (count != '0) ? mem[head] : '0;
  assign stall     = (CW'(DEPTH) - count) < CW'(3);

endmodule

// File: rtl/fu_issue_queue.sv
// Routes up to 3 RS issue slots into per-class FIFOs and presents heads to the FUs (valid/ready).
// Issue-to-FU latency 1 cycle, 0 with FU_QUEUE_BYPASS_EN on an empty ready class; stall from registered counts.
module fu_issue_queue
  import fu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = FUQ_DEPTH,
  parameter int NCLASS = FUQ_NCLASS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  RS_S_PACKET [2:0]        issue_insts,
  input  logic                    squash,
  input  logic [NCLASS-1:0]       fu_ready,
  output RS_S_PACKET [NCLASS-1:0] fu_insts,
  output logic [NCLASS-1:0]       fu_valid,
  output FU_FIFO_PACKET           fu_fifo_stall
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NCLASS-1:0] stall_vec;

  for (genvar c = 0; c < NCLASS; c++) begin : g_cls
    logic [2:0]    route_en;
    logic [2:0]    fifo_wr;
    RS_S_PACKET    head_data;
    logic [CW-1:0] count;
    logic          q_vld;

    always_comb begin
      route_en = '0;
      for (int s = 0; s < 3; s++) begin
        route_en[s] = issue_insts[s].valid &&
                      (int'(fu_class(issue_insts[s].fu_sel)) == c);
      end
    end

    assign q_vld = (count != '0);

`ifdef FU_QUEUE_BYPASS_EN
    logic       byp_ok;
    logic [2:0] byp_sel;
    RS_S_PACKET byp_inst;

    // The winning slot goes straight to the FU and skips the FIFO entirely.
    always_comb begin
      byp_sel  = '0;
      byp_inst = '0;
      if (route_en[2]) begin
        byp_sel = 3'b100; byp_inst = issue_insts[2];
      end else if (route_en[1]) begin
        byp_sel = 3'b010; byp_inst = issue_insts[1];
      end else if (route_en[0]) begin
        byp_sel = 3'b001; byp_inst = issue_insts[0];
      end
    end

    assign byp_ok      = !q_vld && fu_ready[c] && !squash && (route_en != '0);
    assign fifo_wr     = byp_ok ? (route_en & ~byp_sel) : route_en;
    assign fu_valid[c] = q_vld || byp_ok;
    assign fu_insts[c] = byp_ok ? byp_inst : head_data;
`else
    assign fifo_wr     = route_en;
    assign fu_valid[c] = q_vld;
    assign fu_insts[c] = head_data;
`endif

    fu_class_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .squash    (squash),
      .wr_en     (fifo_wr),
      .wr_data   (issue_insts),
      .pop       (q_vld && fu_ready[c]),
      .head_data (head_data),
      .count     (count),
      .stall     (stall_vec[c])
    );
  end

  assign fu_fifo_stall.alu    = stall_vec[FUQ_ALU];
  assign fu_fifo_stall.ls     = stall_vec[FUQ_LS];
  assign fu_fifo_stall.mult   = stall_vec[FUQ_MULT];
  assign fu_fifo_stall.branch = stall_vec[FUQ_BR];

endmodule
